// File: rtl/hdr_pkg.sv
// Shared constants, types and helpers for the HDR range compressor.
package hdr_pkg;

    localparam int HDR_IN_WIDTH  = 34;
    localparam int HDR_OUT_WIDTH = 8;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } hdr_sb_t;

    function automatic int shift_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/hdr_lead_one.sv
// Combinational leading-one detector: index of the highest set bit.
module hdr_lead_one
    import hdr_pkg::*;
#(
    parameter int W = HDR_IN_WIDTH
) (
    input  logic [W-1:0]          value,
    output logic [shift_w(W)-1:0] index,
    output logic                  zero
);

    localparam int IW = shift_w(W);

    always_comb begin
        index = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) index = IW'(i);
        end
        zero = (value == '0);
    end

endmodule

// File: rtl/hdr_range_compress.sv
// Frame-peak driven HDR range compressor, 2-cycle latency.
// Optional rounding before the shift: define HDR_RC_ROUND_EN.
module hdr_range_compress
    import hdr_pkg::*;
#(
    parameter int IN_WIDTH  = HDR_IN_WIDTH,
    parameter int OUT_WIDTH = HDR_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          asi_snk_valid_i,
    input  logic                          asi_snk_startofpacket_i,
    input  logic                          asi_snk_endofpacket_i,
    input  logic [IN_WIDTH-1:0]           asi_snk_data_r_i,
    input  logic [IN_WIDTH-1:0]           asi_snk_data_g_i,
    input  logic [IN_WIDTH-1:0]           asi_snk_data_b_i,
    output logic                          aso_src_valid_o,
    output logic                          aso_src_startofpacket_o,
    output logic                          aso_src_endofpacket_o,
    output logic [OUT_WIDTH-1:0]          aso_src_data_r_o,
    output logic [OUT_WIDTH-1:0]          aso_src_data_g_o,
    output logic [OUT_WIDTH-1:0]          aso_src_data_b_o,
    output logic [shift_w(IN_WIDTH)-1:0]  shift_o,
    output logic [IN_WIDTH-1:0]           peak_o
);

    localparam int SW = shift_w(IN_WIDTH);
    localparam int XW = IN_WIDTH + 1;
    localparam logic [SW-1:0] RST_SHIFT = SW'(IN_WIDTH - OUT_WIDTH);
    localparam logic [SW:0] OUT_W = (SW+1)'(OUT_WIDTH);

    hdr_sb_t sb_in, sb1, sb2;
    logic [IN_WIDTH-1:0] max_rgb, peak_acc, peak_nxt;
    logic [SW-1:0] lead_idx, shift_q, shift_nxt, sh1;
    logic [SW:0] msb_cnt;
    logic lead_zero;
    logic [XW-1:0] rnd, x1_r, x1_g, x1_b;

    assign sb_in = '{valid: asi_snk_valid_i,
                     sop:   asi_snk_startofpacket_i,
                     eop:   asi_snk_endofpacket_i};

    always_comb begin
        max_rgb = asi_snk_data_r_i;
        if (asi_snk_data_g_i > max_rgb) max_rgb = asi_snk_data_g_i;
        if (asi_snk_data_b_i > max_rgb) max_rgb = asi_snk_data_b_i;
        peak_nxt = max_rgb;
        if (!sb_in.sop && peak_acc > max_rgb) peak_nxt = peak_acc;
    end

    hdr_lead_one #(.W(IN_WIDTH)) u_lead_one (
        .value (peak_nxt),
        .index (lead_idx),
        .zero  (lead_zero)
    );

    // Keep the top OUT_WIDTH significant bits of the frame peak.
    always_comb begin
        msb_cnt   = {1'b0, lead_idx} + 1'b1;
        shift_nxt = '0;
        if (!lead_zero && msb_cnt > OUT_W) shift_nxt = SW'(msb_cnt - OUT_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_acc <= '0;
            peak_o   <= '0;
            shift_q  <= RST_SHIFT;
        end else if (sb_in.valid) begin
            peak_acc <= peak_nxt;
            if (sb_in.eop) begin
                peak_o  <= peak_nxt;
                shift_q <= shift_nxt;
            end
        end
    end

    assign shift_o = shift_q;

`ifdef HDR_RC_ROUND_EN
    always_comb begin
        rnd = '0;
        if (shift_q != '0) rnd = XW'(1) << (shift_q - 1'b1);
    end
`else
    assign rnd = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb1  <= '0;
            sh1  <= RST_SHIFT;
            x1_r <= '0;
            x1_g <= '0;
            x1_b <= '0;
        end else begin
            sb1  <= sb_in;
            sh1  <= shift_q;
            x1_r <= {1'b0, asi_snk_data_r_i} + rnd;
            x1_g <= {1'b0, asi_snk_data_g_i} + rnd;
            x1_b <= {1'b0, asi_snk_data_b_i} + rnd;
        end
    end

    function automatic logic [OUT_WIDTH-1:0] scale(
        input logic [XW-1:0] x, input logic [SW-1:0] sh);
        logic [XW-1:0] y;
        y = x >> sh;
        if ((y >> OUT_WIDTH) != '0) return '1;
        return y[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb2              <= '0;
            aso_src_data_r_o <= '0;
            aso_src_data_g_o <= '0;
            aso_src_data_b_o <= '0;
        end else begin
            sb2 <= sb1;
            if (sb1.valid) begin
                aso_src_data_r_o <= scale(x1_r, sh1);
                aso_src_data_g_o <= scale(x1_g, sh1);
                aso_src_data_b_o <= scale(x1_b, sh1);
            end
        end
    end

    assign aso_src_valid_o         = sb2.valid;
    assign aso_src_startofpacket_o = sb2.sop;
    assign aso_src_endofpacket_o   = sb2.eop;

endmodule
